// File: rtl/control_sequencer_if.sv
// Bus between the machine-step/IR/flag sources and the control sequencer.
// The sequencer takes the slave view; whatever drives steps and opcodes takes the master view.
interface control_sequencer_if;
  logic        step_en;
  logic [3:0]  ir_op;
  logic        zf;
  logic        cf;
  logic [15:0] control_word;
  logic [2:0]  step;
  logic        halted;
  logic        instr_done;

  modport master (
    output step_en, ir_op, zf, cf,
    input  control_word, step, halted, instr_done
  );

  modport slave (
    input  step_en, ir_op, zf, cf,
    output control_word, step, halted, instr_done
  );
endinterface

// File: rtl/control_sequencer.sv
// Control unit for the 8-bit bus computer: steps T0..T4, decodes the 16-bit control word
// from step/opcode/flags, and latches HLT until clr.
module control_sequencer #(
  parameter bit EARLY_END = 1'b1
) (
  input  logic               clk,
  input  logic               clr,
  control_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  step_e step_q;
  logic  halted_q;
  logic  instr_done_q;

  logic [2:0] step_v;
  logic       advance;
  logic       at_last;
  logic       do_halt;

  function automatic logic [15:0] ucode(input logic [2:0] s, input logic [3:0] op,
                                        input logic z, input logic c);
    logic [15:0] w;
    w = 16'h0000;
    case (s)
      3'd0: w = 16'h2002;
      3'd1: w = 16'h1028;
      3'd2: begin
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4: w = 16'h0012;
          4'h5:                   w = 16'h0050;
          4'h6:                   w = 16'h4010;
          4'h7:                   w = c ? 16'h4010 : 16'h0000;
          4'h8:                   w = z ? 16'h4010 : 16'h0000;
          4'hE:                   w = 16'h0880;
          4'hF:                   w = 16'h0001;
          default:                w = 16'h0000;
        endcase
      end
      3'd3: begin
        case (op)
          4'h1:       w = 16'h0048;
          4'h2, 4'h3: w = 16'h0408;
          4'h4:       w = 16'h0084;
          default:    w = 16'h0000;
        endcase
      end
      3'd4: begin
        case (op)
          4'h2:    w = 16'h8140;
          4'h3:    w = 16'h8340;
          default: w = 16'h0000;
        endcase
      end
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Conditional jumps count T2 as their last step even when the branch is not taken.
  function automatic logic [2:0] last_step(input logic [3:0] op);
    logic [2:0] l;
    case (op)
      4'h1, 4'h4:                                   l = 3'd3;
      4'h2, 4'h3:                                   l = 3'd4;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF:           l = 3'd2;
      default:                                      l = 3'd1;
    endcase
    return l;
  endfunction

  always_comb begin
    step_v  = step_q;
    advance = bus.step_en && !halted_q;
    do_halt = (step_q == T2) && (bus.ir_op == 4'hF);
    if (EARLY_END) begin
      at_last = (step_v >= last_step(bus.ir_op));
    end else begin
      at_last = (step_q == T4);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step_q       <= T0;
      halted_q     <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      instr_done_q <= 1'b0;
      if (advance) begin
        if (do_halt) begin
          halted_q <= 1'b1;
        end else if (at_last) begin
          step_q       <= T0;
          instr_done_q <= 1'b1;
        end else begin
          step_q <= step_e'(step_v + 3'd1);
        end
      end
    end
  end

  assign bus.control_word = halted_q ? 16'h0001 : ucode(step_v, bus.ir_op, bus.zf, bus.cf);
  assign bus.step         = step_v;
  assign bus.halted       = halted_q;
  assign bus.instr_done   = instr_done_q;

endmodule
